id_ex_hazard_reg: RTL and testbench
===================================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with integrated hazard control, directly upstream of the forwarding unit.
//  - Registers decoded operands and controls into EX; its ex_source_reg1/2, ex_dest_reg and ex_reg_write feed the forwarding unit.
//  - Detects load-use hazards, the one case forwarding cannot cover, and inserts a single bubble.
//  - Holds multi-cycle EX ops (mul/div) for MULDIV_LAT cycles; applies branch flushes.
// PARAMETERS
//  DATA_W      32  operand/immediate width
//  REG_ADDR_W  5   register address width
//  MULDIV_LAT  4   EX occupancy in cycles of an op with id_multi=1; legal range >=1
//  STALL_CNT_W 16  width of stall_cycles; only used with HAZARD_STATS_EN
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           synchronous reset, active low
//  id_valid       in   1           ID holds a real instruction
//  id_rs,id_rt    in   REG_ADDR_W  source register addresses
//  id_rd          in   REG_ADDR_W  destination register address
//  id_rs_data     in   DATA_W      register-file read data for rs
//  id_rt_data     in   DATA_W      register-file read data for rt
//  id_imm         in   DATA_W      sign-extended immediate
//  id_reg_write   in   1           instruction writes a register
//  id_mem_read    in   1           instruction is a load
//  id_mem_write   in   1           instruction is a store
//  id_alu_op      in   4           ALU operation code
//  id_multi       in   1           multi-cycle EX op
//  flush          in   1           branch mispredict; kill the ID instruction
//  stall_if_id    out  1           freeze PC and IF/ID this cycle
//  ex_busy        out  1           multi-cycle op still occupying EX
//  ex_valid       out  1           EX holds a real instruction
//  ex_source_reg1 out  REG_ADDR_W  rs in EX, to forwarding unit
//  ex_source_reg2 out  REG_ADDR_W  rt in EX, to forwarding unit
//  ex_dest_reg    out  REG_ADDR_W  rd in EX
//  ex_rs_data     out  DATA_W      registered rs data
//  ex_rt_data     out  DATA_W      registered rt data
//  ex_imm         out  DATA_W      registered immediate
//  ex_reg_write   out  1           registered control
//  ex_mem_read    out  1           registered control
//  ex_mem_write   out  1           registered control
//  ex_alu_op      out  4           registered control
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all ex_* outputs = 0, state=RUN, cnt=0; stall_if_id=0 and ex_busy=0 while in reset.
//  - Bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write = 0; all addresses = 0, so the forwarding unit's reg!=0 check suppresses it.
//    Data fields are don't-care; they drive 0.
//  - Load-use (combinational):
//    lu = ex_valid & ex_mem_read & ex_dest_reg!=0 & id_valid & (ex_dest_reg==id_rs | ex_dest_reg==id_rt).
//  - State RUN:
//    - stall_if_id = lu.
//    - Next edge: flush -> bubble; else lu -> bubble (ID held upstream, load moves on); else load ID fields (bubble if id_valid=0).
//    - Loading a valid id_multi op with MULDIV_LAT>1 sets cnt=MULDIV_LAT-1 and next state MULTI.
//  - State MULTI:
//    - ex_busy=1 and stall_if_id=1; ex_* are held; cnt decrements each edge.
//    - At cnt==1: next state RUN with cnt=0. The op occupies EX for exactly MULDIV_LAT cycles.
//  - flush priority: flush overrides lu and MULTI. Next edge gives a bubble, state RUN, cnt=0; stall_if_id is not asserted because of flush alone.
//  - MULDIV_LAT=1: MULTI is never entered.
//  - Back-to-back loads: a dependent instruction gets exactly 1 bubble. After the bubble, lu re-evaluates against the new EX contents.
//  - Mid-operation reset: discards MULTI state and any pending bubble immediately.
// CONFIGURATION
//  - HAZARD_STATS_EN defined: extra port stall_cycles out [STALL_CNT_W-1:0].
//    - Counts cycles with stall_if_id=1, saturates at all-ones, cleared by reset.
//  - HAZARD_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1 rst_n=0 for 2 cycles with id_valid=1 and all inputs nonzero -> all ex_*=0, stall_if_id=0, ex_busy=0.
//  2 EX holds lw dest=8; ID add rs=8 -> stall_if_id=1 for 1 cycle; next cycle ex_valid=0; the cycle after, ex_source_reg1=8 and ex_valid=1.
//  3 EX holds lw dest=0; ID rs=0 -> no stall; add enters EX next cycle.
//  4 id_multi op with MULDIV_LAT=4 -> ex_busy=1 and stall_if_id=1 for 3 cycles; ex_* held 4 cycles; next ID instruction enters after.
//  5 flush=1 in MULTI at cnt=2 -> next cycle bubble, ex_busy=0, stall_if_id=0, state RUN.
//  6 HAZARD_STATS_EN: after tests 2 and 4, stall_cycles=4; force saturation (STALL_CNT_W=2) -> stays 3.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, multi-cycle EX hold and branch flush.
// Optional stall statistics counter is compiled in when HAZARD_STATS_EN is defined.
module id_ex_hazard_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MULDIV_LAT  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic [DATA_W-1:0]      id_rs_data,
  input  logic [DATA_W-1:0]      id_rt_data,
  input  logic [DATA_W-1:0]      id_imm,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic [3:0]             id_alu_op,
  input  logic                   id_multi,
  input  logic                   flush,
  output logic                   stall_if_id,
  output logic                   ex_busy,
  output logic                   ex_valid,
  output logic [REG_ADDR_W-1:0]  ex_source_reg1,
  output logic [REG_ADDR_W-1:0]  ex_source_reg2,
  output logic [REG_ADDR_W-1:0]  ex_dest_reg,
  output logic [DATA_W-1:0]      ex_rs_data,
  output logic [DATA_W-1:0]      ex_rt_data,
  output logic [DATA_W-1:0]      ex_imm,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic [3:0]             ex_alu_op
`ifdef HAZARD_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  if (MULDIV_LAT < 1) begin : g_bad_muldiv_lat
    $error("MULDIV_LAT must be >= 1");
  end
  if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
    $error("STALL_CNT_W must be >= 1");
  end

  localparam int unsigned CntW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_LAT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam bit MultiEn = (MULDIV_LAT > 1);

  typedef enum logic [0:0] {
    StRun,
    StMulti
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [3:0]            alu_op;
  } ex_pkt_t;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  ex_pkt_t           ex_q, ex_d;
  ex_pkt_t           id_pkt;
  logic              load_use;

  always_comb begin
    id_pkt           = '0;
    id_pkt.valid     = 1'b1;
    id_pkt.rs        = id_rs;
    id_pkt.rt        = id_rt;
    id_pkt.rd        = id_rd;
    id_pkt.rs_data   = id_rs_data;
    id_pkt.rt_data   = id_rt_data;
    id_pkt.imm       = id_imm;
    id_pkt.reg_write = id_reg_write;
    id_pkt.mem_read  = id_mem_read;
    id_pkt.mem_write = id_mem_write;
    id_pkt.alu_op    = id_alu_op;
  end

  // Only a load result is unavailable for forwarding next cycle; r0 never creates a dependency.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
               ((ex_q.rd == id_rs) | (ex_q.rd == id_rt));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    if (flush) begin
      state_d = StRun;
      cnt_d   = '0;
      ex_d    = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use || !id_valid) begin
            ex_d = '0;
          end else begin
            ex_d = id_pkt;
            if (id_multi && MultiEn) begin
              state_d = StMulti;
              cnt_d   = CntLoad;
            end
          end
        end
        StMulti: begin
          if (cnt_q == CntOne) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
          ex_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  // Gated by rst_n so nothing upstream freezes while the register is being reset.
  always_comb begin
    ex_busy     = rst_n & (state_q == StMulti);
    stall_if_id = rst_n & ((state_q == StMulti) | ((state_q == StRun) & load_use));
  end

  assign ex_valid       = ex_q.valid;
  assign ex_source_reg1 = ex_q.rs;
  assign ex_source_reg2 = ex_q.rt;
  assign ex_dest_reg    = ex_q.rd;
  assign ex_rs_data     = ex_q.rs_data;
  assign ex_rt_data     = ex_q.rt_data;
  assign ex_imm         = ex_q.imm;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_alu_op      = ex_q.alu_op;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed self-checking bench for id_ex_hazard_reg (default parameters, MULDIV_LAT=4).
module tb_id_ex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [3:0]  id_alu_op;
  logic        id_multi;
  logic        flush;
  logic        stall_if_id, ex_busy, ex_valid;
  logic [4:0]  ex_source_reg1, ex_source_reg2, ex_dest_reg;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_alu_op;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_alu_op      (id_alu_op),
    .id_multi       (id_multi),
    .flush          (flush),
    .stall_if_id    (stall_if_id),
    .ex_busy        (ex_busy),
    .ex_valid       (ex_valid),
    .ex_source_reg1 (ex_source_reg1),
    .ex_source_reg2 (ex_source_reg2),
    .ex_dest_reg    (ex_dest_reg),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_alu_op      (ex_alu_op)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic rw,
                        input logic mr, input logic mw, input logic [3:0] op,
                        input logic multi);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_rd        = rd;
    id_rs_data   = rsd;
    id_rt_data   = rsd ^ 32'hFFFF_0000;
    id_imm       = {27'd0, rd};
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = mw;
    id_alu_op    = op;
    id_multi     = multi;
  endtask

  initial begin
    flush = 1'b0;
    rst_n = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
    #1;
    check_eq("rst_stall_comb", {31'd0, stall_if_id}, 32'd0);
    check_eq("rst_busy_comb", {31'd0, ex_busy}, 32'd0);
    tick();
    tick();
    check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_ex_dest", {27'd0, ex_dest_reg}, 32'd0);
    check_eq("rst_ex_src1", {27'd0, ex_source_reg1}, 32'd0);
    check_eq("rst_ex_rs_data", ex_rs_data, 32'd0);
    check_eq("rst_ex_imm", ex_imm, 32'd0);
    check_eq("rst_ex_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, 1'b0}, 32'd0);
    check_eq("rst_ex_alu_op", {28'd0, ex_alu_op}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_if_id}, 32'd0);
    check_eq("rst_busy", {31'd0, ex_busy}, 32'd0);

    // Load-use on rs: lw r8 then add using r8.
    rst_n = 1'b1;
    set_id(1'b1, 5'd1, 5'd0, 5'd8, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0);
    tick();
    check_eq("lw_ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("lw_ex_dest", {27'd0, ex_dest_reg}, 32'd8);
    check_eq("lw_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
    set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'h0000_0011, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    #1;
    check_eq("lu_stall", {31'd0, stall_if_id}, 32'd1);
    tick();
    check_eq("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("lu_bubble_dest", {27'd0, ex_dest_reg}, 32'd0);
    check_eq("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    check_eq("lu_stall_released", {31'd0, stall_if_id}, 32'd0);
    tick();
    check_eq("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("lu_add_src1", {27'd0, ex_source_reg1}, 32'd8);
    check_eq("lu_add_src2", {27'd0, ex_source_reg2}, 32'd2);
    check_eq("lu_add_rs_data", ex_rs_data, 32'h0000_0011);
    check_eq("lu_add_rt_data", ex_rt_data, 32'hFFFF_0011);

    // Load into r0 never stalls.
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd10, 32'h0000_0022, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    #1;
    check_eq("r0_no_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    check_eq("r0_add_dest", {27'd0, ex_dest_reg}, 32'd10);
    check_eq("r0_add_valid", {31'd0, ex_valid}, 32'd1);

    // Multi-cycle op occupies EX for 4 cycles, busy/stall for the first 3.
    set_id(1'b1, 5'd3, 5'd4, 5'd11, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd12, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("mul_busy_%0d", i), {31'd0, ex_busy}, 32'd1);
      check_eq($sformatf("mul_stall_%0d", i), {31'd0, stall_if_id}, 32'd1);
      check_eq($sformatf("mul_hold_dest_%0d", i), {27'd0, ex_dest_reg}, 32'd11);
      check_eq($sformatf("mul_hold_op_%0d", i), {28'd0, ex_alu_op}, 32'd5);
      tick();
    end
    check_eq("mul_last_busy", {31'd0, ex_busy}, 32'd0);
    check_eq("mul_last_stall", {31'd0, stall_if_id}, 32'd0);
    check_eq("mul_last_dest", {27'd0, ex_dest_reg}, 32'd11);
    tick();
    check_eq("after_mul_dest", {27'd0, ex_dest_reg}, 32'd12);
    check_eq("after_mul_op", {28'd0, ex_alu_op}, 32'd1);
`ifdef HAZARD_STATS_EN
    check_eq("stall_cycles", {16'd0, stall_cycles}, 32'd4);
`endif

    // Flush inside MULTI at cnt=2.
    set_id(1'b1, 5'd3, 5'd4, 5'd13, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 5'd14, 32'h0000_0066, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0);
    tick();
    flush = 1'b1;
    #1;
    check_eq("flush_pre_busy", {31'd0, ex_busy}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_bubble_dest", {27'd0, ex_dest_reg}, 32'd0);
    check_eq("flush_busy", {31'd0, ex_busy}, 32'd0);
    check_eq("flush_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    check_eq("flush_run_dest", {27'd0, ex_dest_reg}, 32'd14);

    // Back-to-back loads: each dependent gets exactly one bubble.
    set_id(1'b1, 5'd1, 5'd0, 5'd8, 32'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 5'd0, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0);
    #1;
    check_eq("b2b_stall1", {31'd0, stall_if_id}, 32'd1);
    tick();
    check_eq("b2b_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    check_eq("b2b_lw2_dest", {27'd0, ex_dest_reg}, 32'd9);
    set_id(1'b1, 5'd2, 5'd9, 5'd10, 32'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    #1;
    check_eq("b2b_stall2_rt", {31'd0, stall_if_id}, 32'd1);

    // Flush overrides load-use: bubble, then ID loads without a second bubble.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_lu_bubble", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_lu_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    check_eq("flush_lu_load", {27'd0, ex_dest_reg}, 32'd10);

    // Reset in the middle of a multi-cycle op.
    set_id(1'b1, 5'd3, 5'd4, 5'd15, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1);
    tick();
    check_eq("mid_busy", {31'd0, ex_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, ex_busy}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    check_eq("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    rst_n = 1'b1;
    set_id(1'b1, 5'd5, 5'd6, 5'd16, 32'h0000_0088, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    tick();
    check_eq("post_rst_dest", {27'd0, ex_dest_reg}, 32'd16);
    check_eq("post_rst_busy", {31'd0, ex_busy}, 32'd0);

    // Invalid ID produces a bubble.
    set_id(1'b0, 5'd5, 5'd6, 5'd17, 32'h0000_0099, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0);
    tick();
    check_eq("idle_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("idle_bubble_mw", {31'd0, ex_mem_write}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
